// File: rtl/dmem_ctrl_if.sv
// -----------------------------------------------------------------------------
// dmem_ctrl_if
// Request/response bus between a load/store master and the data memory
// controller.
//   req_valid  : request present (master -> slave)
//   req_ready  : slave can accept a request this cycle
//   req_we     : 1 = store, 0 = load
//   req_size   : RV32 funct3 access size (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   req_addr   : byte address
//   req_wdata  : right-aligned store data
//   resp_valid : one-cycle response strobe
//   resp_rdata : extended load result, 0 for stores and errors
//   resp_err   : misaligned or illegal-size request, qualified by resp_valid
// -----------------------------------------------------------------------------
interface dmem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl
// Byte-addressable data memory (SIZE x 32-bit words, four byte lanes) with an
// RV32 load/store front end and a fixed request-to-response latency.
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset (memory contents are kept)
//   bus   : dmem_ctrl_if.slave request/response port
// Stores commit and loads sample memory at the acceptance edge; the response
// strobe follows LATENCY cycles later. One request is in flight at a time.
// -----------------------------------------------------------------------------
module dmem_ctrl #(
    parameter int SIZE    = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    dmem_ctrl_if.slave  bus
);
    localparam int         AW       = $clog2(SIZE);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [2:0]  r_size;
    logic [1:0]  r_off;
    logic        r_err;
    logic        r_resp_valid;
    logic        r_resp_err;

    logic          w_accept;
    logic          w_illegal;
    logic          w_misaligned;
    logic          w_err;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_rdword;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_ext;
    logic          w_unused;

    // Upper address bits simply wrap; they are deliberately not decoded.
    assign w_unused = &{1'b0, bus.req_addr[31:AW+2]};

    assign bus.req_ready = (r_state == IDLE);
    assign w_accept      = rst_n && bus.req_valid && (r_state == IDLE);
    assign w_idx         = bus.req_addr[AW+1:2];

    assign w_illegal    = (bus.req_size == 3'b011) || (bus.req_size[2:1] == 2'b11);
    assign w_misaligned = ((bus.req_size[1:0] == 2'b01) && bus.req_addr[0]) ||
                          ((bus.req_size == 3'b010) && (bus.req_addr[1:0] != 2'b00));
    assign w_err        = w_illegal || w_misaligned;

    // One RAM per byte lane so each lane has its own write enable.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] r_mem [SIZE] = '{default: 8'h00};
        logic [7:0] r_rd_byte;
        logic       w_lane_we;
        logic [7:0] w_wbyte;

        // Right-aligned store data is steered onto the lane it belongs to.
        always_comb begin
            w_lane_we = 1'b0;
            w_wbyte   = bus.req_wdata[7:0];
            case (bus.req_size[1:0])
                2'b00: begin
                    w_lane_we = (bus.req_addr[1:0] == 2'(gi));
                    w_wbyte   = bus.req_wdata[7:0];
                end
                2'b01: begin
                    w_lane_we = (bus.req_addr[1] == 1'(gi / 2));
                    w_wbyte   = bus.req_wdata[8*(gi%2) +: 8];
                end
                default: begin
                    w_lane_we = 1'b1;
                    w_wbyte   = bus.req_wdata[8*gi +: 8];
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (w_accept) begin
                if (bus.req_we && !w_err && w_lane_we) begin
                    r_mem[w_idx] <= w_wbyte;
                end
                r_rd_byte <= r_mem[w_idx];
            end
        end

        assign w_rdword[8*gi +: 8] = r_rd_byte;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_size       <= '0;
            r_off        <= '0;
            r_err        <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_we   <= bus.req_we;
                        r_size <= bus.req_size;
                        r_off  <= bus.req_addr[1:0];
                        r_err  <= w_err;
                        if (LATENCY == 1) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= w_err;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd1) begin
                        r_state      <= RESP;
                        r_cnt        <= '0;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= r_err;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_state      <= IDLE;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Extension works on the word sampled at acceptance, so it is valid for
    // any LATENCY including 1.
    always_comb begin
        w_byte = 8'(w_rdword >> {r_off, 3'b000});
        w_half = r_off[1] ? w_rdword[31:16] : w_rdword[15:0];
        case (r_size)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ext = {24'h0, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b101:  w_ext = {16'h0, w_half};
            3'b010:  w_ext = w_rdword;
            default: w_ext = 32'h0;
        endcase
    end

    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_rdata = (r_resp_valid && !r_resp_err && !r_we) ? w_ext : 32'h0;
endmodule

// File: tb/tb_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_ctrl
// Three controllers (LATENCY 1, 2, 4) share one stimulus stream; every
// transaction is compared against a byte-array reference model. Directed
// cases first, then randomized loads/stores.
// -----------------------------------------------------------------------------
module tb_dmem_ctrl;
    localparam int SIZE = 64;
    localparam int NDUT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    always #5 clk = ~clk;

    dmem_ctrl_if bus1 ();
    dmem_ctrl_if bus2 ();
    dmem_ctrl_if bus4 ();

    assign bus1.req_valid = req_valid;
    assign bus1.req_we    = req_we;
    assign bus1.req_size  = req_size;
    assign bus1.req_addr  = req_addr;
    assign bus1.req_wdata = req_wdata;
    assign bus2.req_valid = req_valid;
    assign bus2.req_we    = req_we;
    assign bus2.req_size  = req_size;
    assign bus2.req_addr  = req_addr;
    assign bus2.req_wdata = req_wdata;
    assign bus4.req_valid = req_valid;
    assign bus4.req_we    = req_we;
    assign bus4.req_size  = req_size;
    assign bus4.req_addr  = req_addr;
    assign bus4.req_wdata = req_wdata;

    dmem_ctrl #(.SIZE(SIZE), .LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    dmem_ctrl #(.SIZE(SIZE), .LATENCY(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    dmem_ctrl #(.SIZE(SIZE), .LATENCY(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    logic [NDUT-1:0] rv, rdy, rerr;
    logic [31:0]     rdat [NDUT];

    assign rv[0]   = bus1.resp_valid;
    assign rv[1]   = bus2.resp_valid;
    assign rv[2]   = bus4.resp_valid;
    assign rdy[0]  = bus1.req_ready;
    assign rdy[1]  = bus2.req_ready;
    assign rdy[2]  = bus4.req_ready;
    assign rerr[0] = bus1.resp_err;
    assign rerr[1] = bus2.resp_err;
    assign rerr[2] = bus4.resp_err;
    assign rdat[0] = bus1.resp_rdata;
    assign rdat[1] = bus2.resp_rdata;
    assign rdat[2] = bus4.resp_rdata;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] mm [SIZE*4];

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: memory is a flat byte array indexed modulo its byte size.
    task automatic model(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic err);
        int a;
        int nb;
        logic [31:0] v;
        a   = int'(addr % (SIZE * 4));
        nb  = 1 << sz[1:0];
        err = (sz == 3'd3) || (sz > 3'd5) || ((addr % nb) != 0);
        rd  = 32'h0;
        if (err) return;
        if (we) begin
            for (int i = 0; i < nb; i++) mm[a+i] = wd[8*i +: 8];
            return;
        end
        v = 32'h0;
        for (int i = 0; i < nb; i++) v = v | (32'(mm[a+i]) << (8 * i));
        if (!sz[2] && nb < 4 && v[8*nb-1]) v = v | ~((32'h1 << (8 * nb)) - 32'h1);
        rd = v;
    endtask

    task automatic xact(input string name, input logic we, input logic [2:0] sz,
                        input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          first [NDUT];
        int          cnt   [NDUT];
        logic [31:0] got_rd  [NDUT];
        logic        got_err [NDUT];
        model(we, sz, addr, wd, exp_rd, exp_err);
        for (int d = 0; d < NDUT; d++) begin
            first[d] = -1; cnt[d] = 0; got_rd[d] = 32'hx; got_err[d] = 1'bx;
        end
        req_valid = 1'b1; req_we = we; req_size = sz; req_addr = addr; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            if (n > 1) @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                if (n == 1) chk($sformatf("%s/L%0d busy_ready", name, lat_of(d)), 32'(rdy[d]), 32'h0);
                if (rv[d]) begin
                    cnt[d]++;
                    if (first[d] < 0) begin
                        first[d] = n; got_rd[d] = rdat[d]; got_err[d] = rerr[d];
                    end
                end
            end
        end
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("%s/L%0d latency", name, lat_of(d)), 32'(first[d]), 32'(lat_of(d)));
            chk($sformatf("%s/L%0d strobes", name, lat_of(d)), 32'(cnt[d]), 32'h1);
            chk($sformatf("%s/L%0d rdata", name, lat_of(d)), got_rd[d], exp_rd);
            chk($sformatf("%s/L%0d err", name, lat_of(d)), 32'(got_err[d]), 32'(exp_err));
            chk($sformatf("%s/L%0d idle_ready", name, lat_of(d)), 32'(rdy[d]), 32'h1);
        end
        $display("%s we=%0d size=%b addr=%h wdata=%h -> rdata=%h err=%0d",
                 name, we, sz, addr, wd, exp_rd, exp_err);
    endtask

    // Store accepted, then reset pulsed one cycle later: LATENCY 2 and 4
    // must never strobe, but the store stays committed.
    task automatic abort_store();
        logic [31:0] dummy_rd;
        logic        dummy_err;
        int          cnt [NDUT];
        model(1'b1, 3'b010, 32'h10, 32'hA5A5A5A5, dummy_rd, dummy_err);
        for (int d = 0; d < NDUT; d++) cnt[d] = 0;
        req_valid = 1'b1; req_we = 1'b1; req_size = 3'b010; req_addr = 32'h10; req_wdata = 32'hA5A5A5A5;
        @(negedge clk);
        req_valid = 1'b0;
        rst_n     = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            if (n > 1) @(negedge clk);
            if (n == 2) rst_n = 1'b1;
            for (int d = 1; d < NDUT; d++) if (rv[d]) cnt[d]++;
            if (n == 2) begin
                for (int d = 0; d < NDUT; d++)
                    chk($sformatf("abort/L%0d ready_after_rst", lat_of(d)), 32'(rdy[d]), 32'h1);
            end
        end
        for (int d = 1; d < NDUT; d++)
            chk($sformatf("abort/L%0d strobes", lat_of(d)), 32'(cnt[d]), 32'h0);
        $display("abort SW A5A5A5A5 @10 with reset in WAIT");
    endtask

    initial begin
        logic [2:0]  sz_tab [8];
        logic [2:0]  sz;
        logic [31:0] addr;
        int          nb;
        sz_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        for (int i = 0; i < SIZE * 4; i++) mm[i] = 8'h00;

        // A store presented during reset must be ignored.
        rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_size = 3'b010;
        req_addr = 32'h20; req_wdata = 32'hFFFFFFFF;
        repeat (3) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("reset/L%0d resp_valid", lat_of(d)), 32'(rv[d]), 32'h0);
            chk($sformatf("reset/L%0d resp_rdata", lat_of(d)), rdat[d], 32'h0);
            chk($sformatf("reset/L%0d resp_err", lat_of(d)), 32'(rerr[d]), 32'h0);
            chk($sformatf("reset/L%0d req_ready", lat_of(d)), 32'(rdy[d]), 32'h1);
        end
        req_valid = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);

        xact("lw20",   1'b0, 3'b010, 32'h20, 32'h0);
        xact("sw8",    1'b1, 3'b010, 32'h08, 32'hDEADBEEF);
        xact("lw8",    1'b0, 3'b010, 32'h08, 32'h0);
        xact("sb9",    1'b1, 3'b000, 32'h09, 32'h00000080);
        xact("lb9",    1'b0, 3'b000, 32'h09, 32'h0);
        xact("lbu9",   1'b0, 3'b100, 32'h09, 32'h0);
        xact("lw8b",   1'b0, 3'b010, 32'h08, 32'h0);
        xact("lhA",    1'b0, 3'b001, 32'h0A, 32'h0);
        xact("lhuA",   1'b0, 3'b101, 32'h0A, 32'h0);
        xact("sw8b",   1'b1, 3'b010, 32'h08, 32'hDEADBEEF);
        xact("shA",    1'b1, 3'b001, 32'h0A, 32'h00001234);
        xact("lw8c",   1'b0, 3'b010, 32'h08, 32'h0);
        xact("sw6",    1'b1, 3'b010, 32'h06, 32'hCAFEF00D);
        xact("lw4",    1'b0, 3'b010, 32'h04, 32'h0);
        xact("lh3",    1'b0, 3'b001, 32'h03, 32'h0);
        xact("sz011",  1'b0, 3'b011, 32'h08, 32'h0);
        xact("sw100",  1'b1, 3'b010, 32'h100, 32'h11111111);
        xact("lw0",    1'b0, 3'b010, 32'h00, 32'h0);
        abort_store();
        xact("lw10",   1'b0, 3'b010, 32'h10, 32'h0);

        for (int t = 0; t < 150; t++) begin
            sz   = sz_tab[$urandom_range(0, 7)];
            nb   = 1 << sz[1:0];
            addr = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0) addr = addr & ~(32'(nb) - 32'h1);
            xact($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), sz, addr, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
